// File: rtl/uart_pkg.sv
// Shared UART frame definitions: receiver FSM states, frame field sizes and the parity helper.
// The transmit-side framer imports this package as well.
package uart_pkg;

    localparam int unsigned FRAME_BITS      = 11;
    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned FRAMES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    // Even parity: bit equals XOR of data. Odd parity: its complement.
    function automatic logic parity_calc(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_word_assembler_if.sv
// Result bus of the UART word assembler: valid/ready holding register plus error and event pulses.
interface uart_rx_word_assembler_if;
    import uart_pkg::*;

    logic                                 rx_valid;
    logic [DATA_BITS*FRAMES_PER_WORD-1:0] rx_word;
    logic [FRAMES_PER_WORD-1:0]           rx_parity_err;
    logic [FRAMES_PER_WORD-1:0]           rx_frame_err;
    logic                                 rx_overrun;
    logic                                 rx_timeout;
    logic                                 rx_ready;

    modport master (
        output rx_valid, rx_word, rx_parity_err, rx_frame_err, rx_overrun, rx_timeout,
        input  rx_ready
    );

    modport slave (
        input  rx_valid, rx_word, rx_parity_err, rx_frame_err, rx_overrun, rx_timeout,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_bit.sv
// Serial line synchroniser, start detection and per-frame bit timing.
// Emits one byte_done strobe per frame, in the cycle the stop bit is sampled.
module uart_rx_bit
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 byte_done,
    output logic                 line_idle,
    output logic                 line_high,
    output logic                 line_fall
);

    localparam int unsigned    CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

    logic [1:0]           sync_q;
    logic                 prev_q;
    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 rx_s;
    logic                 tick;

    assign rx_s      = sync_q[1];
    assign tick      = (cnt_q == '0);
    assign line_fall = prev_q & ~rx_s;
    assign line_high = rx_s;
    assign line_idle = (state_q == StIdle);
    assign rx_byte   = shift_q;
    assign parity_err = perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        byte_done = 1'b0;
        frame_err = 1'b0;

        // Timed states count down to the next mid-bit sample point.
        if (state_q inside {StStart, StData, StParity, StStop} && !tick) begin
            cnt_d = cnt_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (line_fall) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d = StData;
                        cnt_d   = FullLoad;
                        bit_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FullLoad;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = StParity;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    perr_d  = rx_s ^ parity_calc(shift_q, PARITY_ODD);
                    cnt_d   = FullLoad;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    byte_done = 1'b1;
                    frame_err = ~rx_s;
                    state_d   = rx_s ? StIdle : StBreak;
                end
            end
            StBreak: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Collects four UART frames into one 32-bit word with per-byte error flags, holds it in a
// valid/ready register and discards partial words after a long idle line.
module uart_rx_word_assembler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT      = 16,
    parameter bit          PARITY_ODD        = 1'b0,
    parameter int unsigned IDLE_TIMEOUT_BITS = 22
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_in,
    uart_rx_word_assembler_if.master   rx_bus
);

    localparam int unsigned WordW         = DATA_BITS * FRAMES_PER_WORD;
    localparam int unsigned IdxW          = $clog2(FRAMES_PER_WORD);
    localparam int unsigned TimeoutCycles = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned ToW           = $clog2(TimeoutCycles + 1);

    logic [DATA_BITS-1:0]       rx_byte;
    logic                       parity_err, frame_err, byte_done;
    logic                       line_idle, line_high, line_fall;

    logic [IdxW-1:0]            idx_q, idx_d;
    logic [WordW-1:0]           word_acc_q, word_acc_d;
    logic [FRAMES_PER_WORD-1:0] perr_acc_q, perr_acc_d;
    logic [FRAMES_PER_WORD-1:0] ferr_acc_q, ferr_acc_d;
    logic [ToW-1:0]             to_cnt_q, to_cnt_d;
    logic                       valid_q, valid_d;
    logic [WordW-1:0]           word_q, word_d;
    logic [FRAMES_PER_WORD-1:0] perr_q, perr_d;
    logic [FRAMES_PER_WORD-1:0] ferr_q, ferr_d;
    logic                       overrun_q, overrun_d;
    logic                       timeout_q, timeout_d;

    uart_rx_bit #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY_ODD   (PARITY_ODD)
    ) u_bit (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .rx_byte    (rx_byte),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .byte_done  (byte_done),
        .line_idle  (line_idle),
        .line_high  (line_high),
        .line_fall  (line_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            word_acc_q <= '0;
            perr_acc_q <= '0;
            ferr_acc_q <= '0;
            to_cnt_q   <= '0;
            valid_q    <= 1'b0;
            word_q     <= '0;
            perr_q     <= '0;
            ferr_q     <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            word_acc_q <= word_acc_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            to_cnt_q   <= to_cnt_d;
            valid_q    <= valid_d;
            word_q     <= word_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        idx_d      = idx_q;
        word_acc_d = word_acc_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        to_cnt_d   = to_cnt_q;
        valid_d    = valid_q;
        word_d     = word_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;

        if (valid_q && rx_bus.rx_ready) begin
            valid_d = 1'b0;
        end

        if (byte_done) begin
            word_acc_d[int'(idx_q)*DATA_BITS +: DATA_BITS] = rx_byte;
            perr_acc_d[idx_q] = parity_err;
            ferr_acc_d[idx_q] = frame_err;
            idx_d             = idx_q + 1'b1;
            to_cnt_d          = '0;
            if (idx_q == IdxW'(FRAMES_PER_WORD - 1)) begin
                // A held word that is not being taken this cycle wins; the new one is lost.
                if (!valid_q || rx_bus.rx_ready) begin
                    valid_d = 1'b1;
                    word_d  = word_acc_d;
                    perr_d  = perr_acc_d;
                    ferr_d  = ferr_acc_d;
                end else begin
                    overrun_d = 1'b1;
                end
                perr_acc_d = '0;
                ferr_acc_d = '0;
            end
        end else if (!line_idle || line_fall || idx_q == '0) begin
            to_cnt_d = '0;
        end else if (line_high) begin
            if (to_cnt_q == ToW'(TimeoutCycles - 1)) begin
                timeout_d  = 1'b1;
                idx_d      = '0;
                to_cnt_d   = '0;
                word_acc_d = '0;
                perr_acc_d = '0;
                ferr_acc_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    assign rx_bus.rx_valid      = valid_q;
    assign rx_bus.rx_word       = word_q;
    assign rx_bus.rx_parity_err = perr_q;
    assign rx_bus.rx_frame_err  = ferr_q;
    assign rx_bus.rx_overrun    = overrun_q;
    assign rx_bus.rx_timeout    = timeout_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Scoreboard bench for the UART word assembler: directed frames in, expected words queued,
// monitors compare each accepted word. An odd-parity instance covers the PARITY_ODD build.
module tb_uart_rx_word_assembler;

    localparam int unsigned CPB     = 16;
    localparam int unsigned TO_BITS = 22;

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  perr;
        logic [3:0]  ferr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_e  = 1'b1;
    logic rx_o  = 1'b1;

    int errors  = 0;
    int checks  = 0;
    int ovr_cnt = 0;
    int to_cnt  = 0;

    exp_t q_e[$];
    exp_t q_o[$];

    uart_rx_word_assembler_if bus_e ();
    uart_rx_word_assembler_if bus_o ();

    uart_rx_word_assembler #(
        .CLKS_PER_BIT      (CPB),
        .PARITY_ODD        (1'b0),
        .IDLE_TIMEOUT_BITS (TO_BITS)
    ) dut_e (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_in  (rx_e),
        .rx_bus (bus_e)
    );

    uart_rx_word_assembler #(
        .CLKS_PER_BIT      (CPB),
        .PARITY_ODD        (1'b1),
        .IDLE_TIMEOUT_BITS (TO_BITS)
    ) dut_o (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_in  (rx_o),
        .rx_bus (bus_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic par_bit(input logic [7:0] d, input bit odd);
        return odd ? ~(^d) : (^d);
    endfunction

    task automatic drive_bit(input bit odd_line, input logic v);
        if (odd_line) rx_o = v;
        else          rx_e = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit odd_line, input logic [7:0] data, input bit flip,
                              input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, par_bit(data, odd_line) ^ flip, data, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(odd_line, f[i]);
    endtask

    task automatic send_word(input bit odd_line, input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_frame(odd_line, w[8*k +: 8], 1'b0, 1'b1, 11);
    endtask

    // Monitors: compare each word as the consumer accepts it.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_e.rx_valid && bus_e.rx_ready) begin
            if (q_e.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL even_unexpected_word: got 0x%0h, expected no word", bus_e.rx_word);
            end else begin
                e = q_e.pop_front();
                check("even_word", bus_e.rx_word, e.word);
                check("even_parity_err", 32'(bus_e.rx_parity_err), 32'(e.perr));
                check("even_frame_err", 32'(bus_e.rx_frame_err), 32'(e.ferr));
            end
        end
        if (bus_e.rx_overrun) ovr_cnt++;
        if (bus_e.rx_timeout) to_cnt++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus_o.rx_valid && bus_o.rx_ready) begin
            if (q_o.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL odd_unexpected_word: got 0x%0h, expected no word", bus_o.rx_word);
            end else begin
                e = q_o.pop_front();
                check("odd_word", bus_o.rx_word, e.word);
                check("odd_parity_err", 32'(bus_o.rx_parity_err), 32'(e.perr));
                check("odd_frame_err", 32'(bus_o.rx_frame_err), 32'(e.ferr));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        bus_e.rx_ready = 1'b1;
        bus_o.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus_e.rx_valid), 32'd0);
        check("reset_word", bus_e.rx_word, 32'd0);
        check("reset_flags", {24'd0, bus_e.rx_parity_err, bus_e.rx_frame_err}, 32'd0);
        check("reset_pulses", {30'd0, bus_e.rx_overrun, bus_e.rx_timeout}, 32'd0);
        rst_n = 1'b1;
        drive_bit(1'b0, 1'b1);

        // Clean word; valid must rise exactly 11 cycles into the 4th stop bit.
        q_e.push_back('{32'hA5C30F81, 4'b0000, 4'b0000});
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'h0F, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 10);
        rx_e = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("latency_before_stop_sample", 32'(bus_e.rx_valid), 32'd0);
        @(posedge clk);
        #1;
        check("latency_after_stop_sample", 32'(bus_e.rx_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;

        // Parity error on byte 2.
        q_e.push_back('{32'hA5C30F81, 4'b0100, 4'b0000});
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'h0F, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'hC3, 1'b1, 1'b1, 11);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 11);
        drive_bit(1'b0, 1'b1);

        // Framing error on byte 1 followed by a long low (break) period.
        q_e.push_back('{32'hA5C30F81, 4'b0000, 4'b0010});
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 11);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 11);
        drive_bit(1'b0, 1'b1);

        // Short glitch must not start a frame or advance the byte index.
        rx_e = 1'b0;
        repeat (CPB / 2 - 2) @(posedge clk);
        #1;
        rx_e = 1'b1;
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        check("glitch_no_valid", 32'(bus_e.rx_valid), 32'd0);
        q_e.push_back('{32'hA5C30F81, 4'b0000, 4'b0000});
        send_word(1'b0, 32'hA5C30F81);
        drive_bit(1'b0, 1'b1);

        // Overrun: second word dropped while the first is held.
        bus_e.rx_ready = 1'b0;
        ovr_cnt = 0;
        q_e.push_back('{32'hDEADBEEF, 4'b0000, 4'b0000});
        send_word(1'b0, 32'hDEADBEEF);
        drive_bit(1'b0, 1'b1);
        check("held_valid", 32'(bus_e.rx_valid), 32'd1);
        send_word(1'b0, 32'h12345678);
        drive_bit(1'b0, 1'b1);
        check("overrun_pulse_cycles", 32'(ovr_cnt), 32'd1);
        check("held_word_kept", bus_e.rx_word, 32'hDEADBEEF);
        bus_e.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop_after_accept", 32'(bus_e.rx_valid), 32'd0);
        drive_bit(1'b0, 1'b1);

        // Idle timeout discards a partial word.
        to_cnt = 0;
        send_frame(1'b0, 8'hAA, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'hBB, 1'b0, 1'b1, 11);
        repeat (300) @(posedge clk);
        #1;
        check("timeout_not_early", 32'(to_cnt), 32'd0);
        repeat (60) @(posedge clk);
        #1;
        check("timeout_pulse_cycles", 32'(to_cnt), 32'd1);
        q_e.push_back('{32'h44332211, 4'b0000, 4'b0000});
        send_word(1'b0, 32'h44332211);
        drive_bit(1'b0, 1'b1);

        // Asynchronous reset during DATA of byte 1, with a word held.
        bus_e.rx_ready = 1'b0;
        q_e.push_back('{32'hCAFE1234, 4'b0000, 4'b0000});
        send_word(1'b0, 32'hCAFE1234);
        drive_bit(1'b0, 1'b1);
        check("pre_reset_valid", 32'(bus_e.rx_valid), 32'd1);
        send_frame(1'b0, 8'h77, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'h66, 1'b0, 1'b1, 5);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(bus_e.rx_valid), 32'd0);
        check("async_reset_word", bus_e.rx_word, 32'd0);
        check("async_reset_flags", {24'd0, bus_e.rx_parity_err, bus_e.rx_frame_err}, 32'd0);
        check("async_reset_pulses", {30'd0, bus_e.rx_overrun, bus_e.rx_timeout}, 32'd0);
        q_e.delete();
        rx_e = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_e.rx_ready = 1'b1;
        drive_bit(1'b0, 1'b1);
        q_e.push_back('{32'h01020304, 4'b0000, 4'b0000});
        send_word(1'b0, 32'h01020304);
        drive_bit(1'b0, 1'b1);
        q_o.push_back('{32'h015AFF00, 4'b0000, 4'b0000});
        send_word(1'b1, 32'h015AFF00);
        drive_bit(1'b1, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("even_queue_drained", 32'(q_e.size()), 32'd0);
        check("odd_queue_drained", 32'(q_o.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
